// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter
//   Round-robin arbiter sharing one Wishbone slave port between NMASTERS
//   masters. A grant is held for a whole wb_cyc burst. A watchdog ends any
//   stalled strobe with an error to the owner so a dead slave cannot lock
//   the bus.
//
// Ports
//   ahb_hclk, ahb_hreset         clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i       per-master controls (one bit per master)
//   m_adr_i/m_sel_i/m_dat_i      packed per-master address/select/write data
//   m_dat_o                      read data broadcast to all masters
//   m_ack_o/m_err_o/m_rty_o      per-master terminations (owner only)
//   s_*                          single slave port
//   gnt_o                        registered one-hot grant
//   timeout_o                    one-cycle pulse when the watchdog fires
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin from the pointer
// GRANT | owner g drives the slave; terminations routed to g; watchdog runs
// ABORT | watchdog fired; slave port idled, terminations dropped until g drops cyc
module wb_bus_arbiter #(
  parameter int AWIDTH   = 8,
  parameter int DWIDTH   = 32,
  parameter int NMASTERS = 2,
  parameter int TIMEOUT  = 16
) (
  input  logic                       ahb_hclk,
  input  logic                       ahb_hreset,
  input  logic [NMASTERS-1:0]        m_cyc_i,
  input  logic [NMASTERS-1:0]        m_stb_i,
  input  logic [NMASTERS-1:0]        m_we_i,
  input  logic [NMASTERS*AWIDTH-1:0] m_adr_i,
  input  logic [NMASTERS*4-1:0]      m_sel_i,
  input  logic [NMASTERS*DWIDTH-1:0] m_dat_i,
  output logic [DWIDTH-1:0]          m_dat_o,
  output logic [NMASTERS-1:0]        m_ack_o,
  output logic [NMASTERS-1:0]        m_err_o,
  output logic [NMASTERS-1:0]        m_rty_o,
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic                       s_we_o,
  output logic [AWIDTH-1:0]          s_adr_o,
  output logic [3:0]                 s_sel_o,
  output logic [DWIDTH-1:0]          s_dat_o,
  input  logic [DWIDTH-1:0]          s_dat_i,
  input  logic                       s_ack_i,
  input  logic                       s_err_i,
  input  logic                       s_rty_i,
  output logic [NMASTERS-1:0]        gnt_o,
  output logic                       timeout_o
);

  localparam int IW = (NMASTERS > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

  state_t                state_q, state_d;
  logic [NMASTERS-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [7:0]            wdog_q, wdog_d;

  logic [IW-1:0]         pick;
  logic                  found;
  logic [IW:0]           cand;
  logic                  cand_req;

  logic                  cyc_g, stb_g, we_g;
  logic [AWIDTH-1:0]     adr_g;
  logic [3:0]            sel_g;
  logic [DWIDTH-1:0]     dat_g;
  logic                  term;
  logic                  fire;

  assign gnt_o   = gnt_q;
  assign m_dat_o = s_dat_i;
  assign term    = s_ack_i | s_err_i | s_rty_i;

  // Signals of the current owner, selected by the stored grant index.
  always_comb begin
    cyc_g = 1'b0;
    stb_g = 1'b0;
    we_g  = 1'b0;
    adr_g = '0;
    sel_g = '0;
    dat_g = '0;
    for (int k = 0; k < NMASTERS; k++) begin
      if (idx_q == IW'(k)) begin
        cyc_g = m_cyc_i[k];
        stb_g = m_stb_i[k];
        we_g  = m_we_i[k];
        adr_g = m_adr_i[k*AWIDTH +: AWIDTH];
        sel_g = m_sel_i[k*4 +: 4];
        dat_g = m_dat_i[k*DWIDTH +: DWIDTH];
      end
    end
  end

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    cand_req = 1'b0;
    for (int i = 0; i < NMASTERS; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NMASTERS))
        cand = cand - (IW+1)'(NMASTERS);
      cand_req = 1'b0;
      for (int k = 0; k < NMASTERS; k++)
        if (cand[IW-1:0] == IW'(k))
          cand_req = m_cyc_i[k];
      if (!found && cand_req) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    wdog_d    = wdog_q;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_adr_o   = '0;
    s_sel_o   = '0;
    s_dat_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_rty_o   = '0;
    timeout_o = 1'b0;
    fire      = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          idx_d   = pick;
          wdog_d  = '0;
          gnt_d   = '0;
          for (int k = 0; k < NMASTERS; k++)
            if (pick == IW'(k))
              gnt_d[k] = 1'b1;
          ptr_d = (pick == IW'(NMASTERS-1)) ? '0 : pick + 1'b1;
        end
      end

      GRANT: begin
        s_cyc_o = cyc_g;
        s_stb_o = stb_g;
        s_we_o  = we_g;
        s_adr_o = adr_g;
        s_sel_o = sel_g;
        s_dat_o = dat_g;
        // A real termination in the last watchdog cycle takes precedence.
        fire      = stb_g && !term && (wdog_q == 8'(TIMEOUT-1));
        timeout_o = fire;
        for (int k = 0; k < NMASTERS; k++) begin
          if (idx_q == IW'(k)) begin
            m_ack_o[k] = s_ack_i;
            m_err_o[k] = s_err_i | fire;
            m_rty_o[k] = s_rty_i;
          end
        end
        if (!cyc_g) begin
          state_d = IDLE;
          gnt_d   = '0;
          wdog_d  = '0;
        end else if (fire) begin
          state_d = ABORT;
          wdog_d  = '0;
        end else if (stb_g && !term) begin
          wdog_d = wdog_q + 8'd1;
        end else begin
          wdog_d = '0;
        end
      end

      ABORT: begin
        if (!cyc_g) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge ahb_hclk or negedge ahb_hreset) begin
    if (!ahb_hreset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;
  localparam int NM = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              ahb_hclk = 1'b0;
  logic              ahb_hreset;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0]  m_adr_i;
  logic [NM*4-1:0]   m_sel_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [3:0]        s_sel_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i, s_rty_i;
  logic [NM-1:0]     gnt_o;
  logic              timeout_o;

  wb_bus_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .NMASTERS(NM), .TIMEOUT(TO)) dut (
    .ahb_hclk(ahb_hclk), .ahb_hreset(ahb_hreset),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  always #5 ahb_hclk = ~ahb_hclk;

  typedef struct {
    int            cyc;
    logic [NM-1:0] gnt;
    logic          scyc, sstb, swe, to, active;
    logic [AW-1:0] adr;
    logic [3:0]    sel;
    logic [DW-1:0] dat, rdat;
  } exp_t;

  typedef struct {
    int            cyc;
    logic [NM-1:0] ack, err, rty;
  } term_t;

  exp_t  exp_q[$];
  term_t term_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc_cnt = 0;

  // Reference model: who owns the bus, whether that ownership was aborted,
  // next master in round-robin order, consecutive unanswered strobes.
  int owner = -1;
  int rr = 0;
  int stall = 0;
  int burst_terms = 0;
  bit aborted = 1'b0;

  task automatic model_reset();
    owner = -1; rr = 0; stall = 0; burst_terms = 0; aborted = 1'b0;
  endtask

  task automatic model_eval();
    exp_t  e;
    term_t t;
    bit    anyt, fire;
    int    c;
    cyc_cnt++;
    e.cyc    = cyc_cnt;
    e.gnt    = '0;
    if (owner >= 0) e.gnt[owner] = 1'b1;
    e.active = (owner >= 0) && !aborted;
    e.scyc = 1'b0; e.sstb = 1'b0; e.swe = 1'b0; e.adr = '0; e.sel = '0; e.dat = '0;
    if (e.active) begin
      e.scyc = m_cyc_i[owner];
      e.sstb = m_stb_i[owner];
      e.swe  = m_we_i[owner];
      e.adr  = m_adr_i[owner*AW +: AW];
      e.sel  = m_sel_i[owner*4 +: 4];
      e.dat  = m_dat_i[owner*DW +: DW];
    end
    e.rdat = s_dat_i;
    anyt = s_ack_i || s_err_i || s_rty_i;
    fire = e.active && m_stb_i[owner] && !anyt && (stall == TO-1);
    e.to = fire;
    if (e.active && (anyt || fire)) begin
      t.cyc = cyc_cnt; t.ack = '0; t.err = '0; t.rty = '0;
      t.ack[owner] = s_ack_i;
      t.err[owner] = s_err_i | fire;
      t.rty[owner] = s_rty_i;
      term_q.push_back(t);
      burst_terms++;
    end
    exp_q.push_back(e);

    if (owner < 0) begin
      for (int i = 0; i < NM; i++) begin
        c = (rr + i) % NM;
        if (owner < 0 && m_cyc_i[c]) owner = c;
      end
      if (owner >= 0) begin
        rr = (owner + 1) % NM;
        stall = 0; aborted = 1'b0; burst_terms = 0;
      end
    end else if (!m_cyc_i[owner]) begin
      owner = -1; stall = 0; aborted = 1'b0;
    end else if (aborted) begin
      stall = 0;
    end else if (fire) begin
      aborted = 1'b1; stall = 0;
    end else if (m_stb_i[owner] && !anyt) begin
      stall++;
    end else begin
      stall = 0;
    end
  endtask

  task automatic drive(input logic [NM-1:0] cyc, input logic [NM-1:0] stb,
                       input logic ack, input logic err, input logic rty);
    @(posedge ahb_hclk); #1;
    m_cyc_i = cyc;
    m_stb_i = stb;
    m_we_i  = NM'($urandom);
    m_adr_i = (NM*AW)'($urandom);
    m_sel_i = (NM*4)'($urandom);
    m_dat_i = (NM*DW)'({$urandom, $urandom});
    s_dat_i = $urandom;
    s_ack_i = ack; s_err_i = err; s_rty_i = rty;
    model_eval();
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: pops the expected picture for every presented cycle and pairs
  // observed terminations with the scoreboard's termination queue.
  always @(negedge ahb_hclk) begin : mon
    exp_t          e;
    term_t         t;
    logic [NM-1:0] gotv;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({gnt_o, s_cyc_o, s_stb_o, timeout_o} !== {e.gnt, e.scyc, e.sstb, e.to}) begin
        errors++;
        $display("FAIL ctrl cyc=%0d got gnt=%b scyc=%b sstb=%b to=%b expected gnt=%b scyc=%b sstb=%b to=%b",
                 e.cyc, gnt_o, s_cyc_o, s_stb_o, timeout_o, e.gnt, e.scyc, e.sstb, e.to);
      end
      if (e.active) begin
        checks++;
        if ({s_we_o, s_adr_o, s_sel_o, s_dat_o} !== {e.swe, e.adr, e.sel, e.dat}) begin
          errors++;
          $display("FAIL slave_mux cyc=%0d got we=%b adr=%h sel=%h dat=%h expected we=%b adr=%h sel=%h dat=%h",
                   e.cyc, s_we_o, s_adr_o, s_sel_o, s_dat_o, e.swe, e.adr, e.sel, e.dat);
        end
      end
      checks++;
      if (m_dat_o !== e.rdat) begin
        errors++;
        $display("FAIL rdata cyc=%0d got %h expected %h", e.cyc, m_dat_o, e.rdat);
      end
      gotv = m_ack_o | m_err_o | m_rty_o;
      if (gotv != '0) begin
        checks++;
        if (term_q.size() == 0 || term_q[0].cyc != e.cyc) begin
          errors++;
          $display("FAIL unexpected_term cyc=%0d got ack=%b err=%b rty=%b expected none",
                   e.cyc, m_ack_o, m_err_o, m_rty_o);
        end else begin
          t = term_q.pop_front();
          if ({m_ack_o, m_err_o, m_rty_o} !== {t.ack, t.err, t.rty}) begin
            errors++;
            $display("FAIL term cyc=%0d got ack=%b err=%b rty=%b expected ack=%b err=%b rty=%b",
                     e.cyc, m_ack_o, m_err_o, m_rty_o, t.ack, t.err, t.rty);
          end
        end
      end else if (term_q.size() > 0 && term_q[0].cyc == e.cyc) begin
        checks++;
        errors++;
        t = term_q.pop_front();
        $display("FAIL missing_term cyc=%0d got none expected ack=%b err=%b rty=%b",
                 e.cyc, t.ack, t.err, t.rty);
      end
    end
  end

  initial begin : time_limit
    #2000000;
    $display("FAIL time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [NM-1:0] seq[$];
    logic [NM-1:0] last, nc, ns, cv;
    logic          a, er, ry;
    int            stbc, mode, r;
    bit            fired;

    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_adr_i = '0; m_sel_i = '0; m_dat_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    ahb_hreset = 1'b0;
    repeat (3) @(posedge ahb_hclk);
    #1;
    check("reset_outputs", {gnt_o, s_cyc_o, s_stb_o, timeout_o, m_ack_o, m_err_o, m_rty_o}, '0);
    @(negedge ahb_hclk);
    ahb_hreset = 1'b1;
    model_reset();

    // Both masters request continuously; each drops cyc after one ack.
    last = '0;
    for (int i = 0; i < 14; i++) begin
      cv = 2'b11;
      if (owner >= 0 && burst_terms >= 1) cv[owner] = 1'b0;
      a = (owner >= 0) && !aborted && cv[owner];
      drive(cv, cv, a, 1'b0, 1'b0);
      #1;
      if (gnt_o != '0 && last == '0) seq.push_back(gnt_o);
      last = gnt_o;
    end
    repeat (2) drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    check("rr_count", 64'(seq.size() >= 3), 64'd1);
    if (seq.size() >= 3) begin
      check("rr_grant0", 64'(seq[0]), 64'b01);
      check("rr_grant1", 64'(seq[1]), 64'b10);
      check("rr_grant2", 64'(seq[2]), 64'b01);
    end

    // Single master, ack on the third strobe cycle of the grant.
    drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    #1 check("grant_latency", 64'(gnt_o), 64'b00);
    drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    #1 check("grant_after_1", 64'(gnt_o), 64'b01);
    drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    drive(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    #1 check("ack_route", 64'(m_ack_o), 64'b01);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 check("grant_release", 64'(gnt_o), 64'b00);

    // Dead slave: error on the TO-th strobe cycle, then the slave port idles.
    stbc = 0; fired = 1'b0;
    for (int i = 0; i < 40 && !fired; i++) begin
      drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
      #1;
      if (gnt_o == 2'b01 && s_stb_o) stbc++;
      if (timeout_o) begin
        fired = 1'b1;
        check("timeout_err", 64'(m_err_o), 64'b01);
      end
    end
    check("timeout_fired", 64'(fired), 64'd1);
    check("timeout_cycles", 64'(stbc), 64'(TO));
    drive(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    #1 check("abort_idle", {s_cyc_o, s_stb_o, m_ack_o}, '0);
    drive(2'b01, 2'b01, 1'b0, 1'b1, 1'b0);
    repeat (2) drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Ack arriving exactly at the last watchdog cycle wins.
    for (int i = 0; i < 40 && !(owner == 0 && !aborted && stall == TO-1); i++)
      drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    drive(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    #1 check("boundary_ack", {m_ack_o, m_err_o, timeout_o}, {2'b01, 2'b00, 1'b0});
    repeat (2) drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Master 1 strobes without a grant while master 0 owns the bus.
    drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      drive(2'b11, 2'b11, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    drive(2'b10, 2'b10, 1'b1, 1'b0, 1'b0);
    repeat (3) drive(2'b10, 2'b10, 1'b1, 1'b0, 1'b0);
    repeat (2) drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a granted cycle.
    repeat (3) drive(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    @(negedge ahb_hclk);
    #2 ahb_hreset = 1'b0;
    #1 check("reset_midcycle", {gnt_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o}, '0);
    m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    repeat (2) @(posedge ahb_hclk);
    @(negedge ahb_hclk);
    ahb_hreset = 1'b1;
    model_reset();
    drive(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    drive(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
    #1 check("restart_master0", 64'(gnt_o), 64'b01);
    repeat (2) drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Randomised traffic against the reference model.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) mode = $urandom_range(0, 3);
      nc = m_cyc_i;
      for (int k = 0; k < NM; k++) begin
        if (!nc[k])
          nc[k] = ($urandom_range(0, 3) == 0);
        else if (owner == k && (aborted || burst_terms >= int'($urandom_range(1, 3))))
          nc[k] = ($urandom_range(0, 2) == 0);
        else if (owner == k && $urandom_range(0, 40) == 0)
          nc[k] = 1'b0;
        ns[k] = nc[k] && (mode >= 2 || $urandom_range(0, 4) != 0);
      end
      a = 1'b0; er = 1'b0; ry = 1'b0;
      r = $urandom_range(0, 19);
      if (mode <= 1) begin
        if (r < 7) a = 1'b1;
        else if (r < 9) er = 1'b1;
        else if (r < 11) ry = 1'b1;
      end else if (mode == 3 && owner >= 0 && !aborted && stall == TO-1) begin
        if (r < 10) a = 1'b1;
        else if (r < 15) er = 1'b1;
        else ry = 1'b1;
      end else if (r == 0) begin
        a = 1'b1;
      end
      drive(nc, ns, a, er, ry);
    end
    repeat (3) drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    @(negedge ahb_hclk);
    #1;
    check("queues_drained", 64'(exp_q.size() + term_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
